// File: rtl/crc32_stream.sv
// crc32_stream: frame-aware Ethernet CRC-32 engine (reflected, poly 0x04C11DB7).
// Consumes DATA_BYTES lanes per beat in ascending lane order, skipping lanes
// whose keep bit is clear, and emits one result beat (FCS + byte length) per frame.
// Optional macro CRC_CHECK_EN enables the receive residue comparator on out_fcs_ok;
// without it out_fcs_ok is tied low.
module crc32_stream #(
    parameter int DATA_BYTES = 8,
    parameter int LEN_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic                    in_sop,
    input  logic                    in_eop,
    input  logic [8*DATA_BYTES-1:0] in_data,
    input  logic [DATA_BYTES-1:0]   in_keep,
    output logic                    out_valid,
    output logic [31:0]             out_crc,
    output logic [LEN_W-1:0]        out_len,
    output logic                    out_err,
    output logic                    out_fcs_ok
);

    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;
`ifdef CRC_CHECK_EN
    localparam logic [31:0] CRC_RESIDUE   = 32'h2144_DF1C;
`endif

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } state_t;

    // One reflected CRC-32 step over a single byte, LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {24'h00_0000, b};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) begin
                c = {1'b0, c[31:1]} ^ CRC_POLY_REFL;
            end else begin
                c = {1'b0, c[31:1]};
            end
        end
        return c;
    endfunction

    // Number of valid lanes in a beat, one bit wider than the length counter.
    function automatic logic [LEN_W:0] keep_count(input logic [DATA_BYTES-1:0] keep);
        logic [LEN_W:0] n;
        n = {(LEN_W+1){1'b0}};
        for (int i = 0; i < DATA_BYTES; i++) begin
            n = n + {{LEN_W{1'b0}}, keep[i]};
        end
        return n;
    endfunction

    state_t             state_r, state_n_s;
    logic [31:0]        lfsr_r, lfsr_n_s;
    logic [LEN_W-1:0]   len_r, len_n_s;
    logic               out_valid_r, out_err_r, out_fcs_ok_r;
    logic [31:0]        out_crc_r;
    logic [LEN_W-1:0]   out_len_r;

    logic               continue_s;
    logic [31:0]        chain_s;
    logic [31:0]        crc_final_s;
    logic [LEN_W-1:0]   base_len_s;
    logic [LEN_W:0]     sum_s;
    logic [LEN_W-1:0]   len_sum_s;
    logic               take_s;
    logic               res_valid_s;
    logic               err_s;
    logic               fcs_match_s;

    // Datapath: byte-step chain seeded from the running register or a fresh init,
    // plus the saturating length accumulation for the current beat.
    always_comb begin
        continue_s = (state_r == ST_FRAME) && !in_sop;
        chain_s    = continue_s ? lfsr_r : CRC_INIT;
        for (int k = 0; k < DATA_BYTES; k++) begin
            if (in_keep[k]) begin
                chain_s = crc_byte(chain_s, in_data[8*k +: 8]);
            end else begin
                chain_s = chain_s;
            end
        end
        crc_final_s = ~chain_s;
        base_len_s  = continue_s ? len_r : {LEN_W{1'b0}};
        sum_s       = {1'b0, base_len_s} + keep_count(in_keep);
        len_sum_s   = sum_s[LEN_W] ? {LEN_W{1'b1}} : sum_s[LEN_W-1:0];
`ifdef CRC_CHECK_EN
        fcs_match_s = (crc_final_s == CRC_RESIDUE);
`else
        fcs_match_s = 1'b0;
`endif
    end

    // Next-state logic: accept, drop or restart frames and flag framing errors.
    always_comb begin
        state_n_s   = state_r;
        lfsr_n_s    = lfsr_r;
        len_n_s     = len_r;
        take_s      = 1'b0;
        err_s       = 1'b0;
        res_valid_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    if (in_sop) begin
                        take_s = 1'b1;
                    end else begin
                        err_s = 1'b1;
                    end
                end else begin
                    take_s = 1'b0;
                end
            end
            ST_FRAME: begin
                if (in_valid) begin
                    take_s = 1'b1;
                    // A new sop here means the previous frame never saw its eop.
                    err_s  = in_sop;
                end else begin
                    take_s = 1'b0;
                end
            end
            default: begin
                state_n_s = ST_IDLE;
                lfsr_n_s  = CRC_INIT;
                len_n_s   = {LEN_W{1'b0}};
            end
        endcase
        if (take_s) begin
            if (in_eop) begin
                res_valid_s = 1'b1;
                state_n_s   = ST_IDLE;
                lfsr_n_s    = CRC_INIT;
                len_n_s     = {LEN_W{1'b0}};
            end else begin
                state_n_s   = ST_FRAME;
                lfsr_n_s    = chain_s;
                len_n_s     = len_sum_s;
            end
        end else begin
            res_valid_s = 1'b0;
        end
    end

    // State, running CRC and length registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            lfsr_r  <= CRC_INIT;
            len_r   <= {LEN_W{1'b0}};
        end else begin
            state_r <= state_n_s;
            lfsr_r  <= lfsr_n_s;
            len_r   <= len_n_s;
        end
    end

    // Result registers: strobes last one cycle, crc/len hold until the next result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r  <= 1'b0;
            out_err_r    <= 1'b0;
            out_fcs_ok_r <= 1'b0;
            out_crc_r    <= 32'h0000_0000;
            out_len_r    <= {LEN_W{1'b0}};
        end else begin
            out_valid_r  <= res_valid_s;
            out_err_r    <= err_s;
            out_fcs_ok_r <= res_valid_s & fcs_match_s;
            if (res_valid_s) begin
                out_crc_r <= crc_final_s;
                out_len_r <= len_sum_s;
            end else begin
                out_crc_r <= out_crc_r;
                out_len_r <= out_len_r;
            end
        end
    end

    assign out_valid  = out_valid_r;
    assign out_err    = out_err_r;
    assign out_fcs_ok = out_fcs_ok_r;
    assign out_crc    = out_crc_r;
    assign out_len    = out_len_r;

endmodule

// File: tb/tb_crc32_stream.sv
// tb_crc32_stream: scenario tasks plus randomized frames checked against a
// bit-serial CRC-32 reference computed over the frame's byte list.
module tb_crc32_stream;

    typedef logic [7:0] bq_t [$];

    logic        clk;
    logic        rst;
    logic        in_valid, in_sop, in_eop;
    logic [63:0] in_data;
    logic [7:0]  in_keep;
    logic        out_valid, out_err, out_fcs_ok;
    logic [31:0] out_crc;
    logic [15:0] out_len;

    int vectors;
    int miscompares;

    crc32_stream #(.DATA_BYTES(8), .LEN_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
        .in_data(in_data), .in_keep(in_keep),
        .out_valid(out_valid), .out_crc(out_crc), .out_len(out_len),
        .out_err(out_err), .out_fcs_ok(out_fcs_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: Ethernet CRC-32 over a byte list, one bit at a time.
    function automatic logic [31:0] ref_crc(input bq_t q);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFF_FFFF;
        foreach (q[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ q[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        end
        return ~c;
    endfunction

    function automatic logic exp_ok(input logic [31:0] crc);
`ifdef CRC_CHECK_EN
        return (crc == 32'h2144_DF1C);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bq_t str_bytes(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    // Apply one beat for one clock; returns 1 ns after the edge.
    task automatic drive(input logic v, input logic s, input logic e,
                         input logic [63:0] d, input logic [7:0] k);
        in_valid = v; in_sop = s; in_eop = e; in_data = d; in_keep = k;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 64'h0, 8'h00);
    endtask

    // Send a byte list as contiguous beats with random idle gaps between beats.
    task automatic send_bytes(input bq_t q, input int max_gap,
                              output logic got_v, output logic [31:0] got_crc,
                              output logic [15:0] got_len, output logic got_ok,
                              output logic got_err, output logic spurious);
        int nb;
        int g;
        logic [63:0] d;
        logic [7:0]  k;
        nb = (q.size() + 7) / 8;
        if (nb == 0) nb = 1;
        spurious = 1'b0;
        for (int b = 0; b < nb; b++) begin
            d = 64'h0;
            k = 8'h00;
            for (int l = 0; l < 8; l++) begin
                if (b*8 + l < q.size()) begin
                    d[8*l +: 8] = q[b*8 + l];
                    k[l] = 1'b1;
                end
            end
            drive(1'b1, b == 0, b == nb-1, d, k);
            if (b != nb-1) begin
                spurious = spurious | out_valid | out_err;
                g = $urandom_range(max_gap, 0);
                for (int j = 0; j < g; j++) begin
                    idle(1);
                    spurious = spurious | out_valid | out_err;
                end
            end
        end
        got_v = out_valid; got_crc = out_crc; got_len = out_len;
        got_ok = out_fcs_ok; got_err = out_err;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle(2);
        vectors++;
        if ({out_valid, out_err, out_fcs_ok} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_strobes got=%b want=000", {out_valid, out_err, out_fcs_ok});
        end
        vectors++;
        if (out_crc !== 32'h0 || out_len !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_data got crc=%h len=%0d want 0/0", out_crc, out_len);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_known;
        logic v, ok, er, sp; logic [31:0] c; logic [15:0] l;
        send_bytes(str_bytes("123456789"), 0, v, c, l, ok, er, sp);
        vectors++;
        if (v !== 1'b1 || c !== 32'hCBF4_3926 || l !== 16'd9 || er !== 1'b0 || sp !== 1'b0) begin
            miscompares++;
            $display("FAIL known_9 got v=%b crc=%h len=%0d err=%b sp=%b want 1/cbf43926/9/0/0", v, c, l, er, sp);
        end
        idle(1);
        vectors++;
        if (out_valid !== 1'b0 || out_crc !== 32'hCBF4_3926 || out_len !== 16'd9) begin
            miscompares++;
            $display("FAIL known_hold got v=%b crc=%h len=%0d want 0/cbf43926/9", out_valid, out_crc, out_len);
        end
    endtask

    task automatic test_single_repeat;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b1, 64'h0000_0000_3433_3231, 8'h0F);
            vectors++;
            if (out_valid !== 1'b1 || out_crc !== 32'h9BE3_E0A3 || out_len !== 16'd4 || out_err !== 1'b0) begin
                miscompares++;
                $display("FAIL single_%0d got v=%b crc=%h len=%0d err=%b want 1/9be3e0a3/4/0", i, out_valid, out_crc, out_len, out_err);
            end
        end
        idle(1);
    endtask

    task automatic test_back_to_back;
        drive(1'b1, 1'b1, 1'b0, 64'h3837_3635_3433_3231, 8'hFF);
        idle(3);
        drive(1'b1, 1'b0, 1'b1, 64'h0000_0000_0000_0039, 8'h01);
        vectors++;
        if (out_valid !== 1'b1 || out_crc !== 32'hCBF4_3926 || out_len !== 16'd9) begin
            miscompares++;
            $display("FAIL gap_frame got v=%b crc=%h len=%0d want 1/cbf43926/9", out_valid, out_crc, out_len);
        end
        drive(1'b1, 1'b1, 1'b1, 64'h0000_0000_3433_3231, 8'h0F);
        vectors++;
        if (out_valid !== 1'b1 || out_crc !== 32'h9BE3_E0A3 || out_len !== 16'd4) begin
            miscompares++;
            $display("FAIL b2b_frame got v=%b crc=%h len=%0d want 1/9be3e0a3/4", out_valid, out_crc, out_len);
        end
        idle(1);
    endtask

    task automatic test_missing_eop;
        drive(1'b1, 1'b1, 1'b0, 64'h3837_3635_3433_3231, 8'hFF);
        vectors++;
        if (out_valid !== 1'b0 || out_err !== 1'b0) begin
            miscompares++;
            $display("FAIL noeop_open got v=%b err=%b want 0/0", out_valid, out_err);
        end
        drive(1'b1, 1'b1, 1'b1, 64'h0000_0000_3433_3231, 8'h0F);
        vectors++;
        if (out_err !== 1'b1 || out_valid !== 1'b1 || out_crc !== 32'h9BE3_E0A3 || out_len !== 16'd4) begin
            miscompares++;
            $display("FAIL noeop_restart got err=%b v=%b crc=%h len=%0d want 1/1/9be3e0a3/4", out_err, out_valid, out_crc, out_len);
        end
        idle(1);
        vectors++;
        if (out_err !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL noeop_after got err=%b v=%b want 0/0", out_err, out_valid);
        end
        drive(1'b1, 1'b0, 1'b1, 64'h1122_3344_5566_7788, 8'hFF);
        vectors++;
        if (out_err !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_nosop got err=%b v=%b want 1/0", out_err, out_valid);
        end
        idle(1);
        vectors++;
        if (out_err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_pulse_width got err=%b want 0", out_err);
        end
    endtask

    task automatic test_fcs;
        logic v, ok, er, sp; logic [31:0] c, pc; logic [15:0] l;
        bq_t q;
        q = str_bytes("123456789");
        q.push_back(8'h26); q.push_back(8'h39); q.push_back(8'hF4); q.push_back(8'hCB);
        send_bytes(q, 2, v, c, l, ok, er, sp);
        vectors++;
        if (v !== 1'b1 || l !== 16'd13 || c !== 32'h2144_DF1C || ok !== exp_ok(32'h2144_DF1C)) begin
            miscompares++;
            $display("FAIL fcs_good got v=%b len=%0d crc=%h ok=%b want 1/13/2144df1c/%b", v, l, c, ok, exp_ok(32'h2144_DF1C));
        end
        idle(1);
        vectors++;
        if (out_fcs_ok !== 1'b0) begin
            miscompares++;
            $display("FAIL fcs_ok_drop got %b want 0", out_fcs_ok);
        end
        q[0] = q[0] ^ 8'h01;
        send_bytes(q, 0, v, c, l, ok, er, sp);
        vectors++;
        if (v !== 1'b1 || ok !== 1'b0 || c !== ref_crc(q)) begin
            miscompares++;
            $display("FAIL fcs_bad got v=%b ok=%b crc=%h want 1/0/%h", v, ok, c, ref_crc(q));
        end
        // Random payloads with their own FCS appended.
        for (int f = 0; f < 8; f++) begin
            q.delete();
            for (int i = 0; i < $urandom_range(40, 1); i++) q.push_back(8'($urandom));
            pc = ref_crc(q);
            for (int i = 0; i < 4; i++) q.push_back(pc[8*i +: 8]);
            send_bytes(q, 2, v, c, l, ok, er, sp);
            vectors++;
            if (v !== 1'b1 || c !== 32'h2144_DF1C || l !== 16'(q.size()) || ok !== exp_ok(32'h2144_DF1C) || sp !== 1'b0) begin
                miscompares++;
                $display("FAIL fcs_rand_%0d got v=%b crc=%h len=%0d ok=%b sp=%b want len=%0d", f, v, c, l, ok, sp, q.size());
            end
        end
        idle(1);
    endtask

    task automatic test_reset_midframe;
        drive(1'b1, 1'b1, 1'b0, 64'h3837_3635_3433_3231, 8'hFF);
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_err !== 1'b0 || out_fcs_ok !== 1'b0 || out_crc !== 32'h0 || out_len !== 16'h0) begin
            miscompares++;
            $display("FAIL async_reset got v=%b err=%b ok=%b crc=%h len=%0d want all 0", out_valid, out_err, out_fcs_ok, out_crc, out_len);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 64'h0000_0000_0000_0039, 8'h01);
        vectors++;
        if (out_err !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_nosop got err=%b v=%b want 1/0", out_err, out_valid);
        end
        drive(1'b1, 1'b1, 1'b0, 64'h3837_3635_3433_3231, 8'hFF);
        drive(1'b1, 1'b0, 1'b1, 64'h0000_0000_0000_0039, 8'h01);
        vectors++;
        if (out_valid !== 1'b1 || out_crc !== 32'hCBF4_3926 || out_len !== 16'd9 || out_err !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_frame got v=%b crc=%h len=%0d err=%b want 1/cbf43926/9/0", out_valid, out_crc, out_len, out_err);
        end
        idle(1);
    endtask

    // Random beat counts, keep masks (non-contiguous, empty eop) and gaps.
    task automatic test_random;
        int nb;
        logic [63:0] d;
        logic [7:0]  k;
        logic        sp;
        logic [31:0] ec;
        bq_t q;
        for (int f = 0; f < 60; f++) begin
            q.delete();
            sp = 1'b0;
            nb = $urandom_range(5, 1);
            for (int b = 0; b < nb; b++) begin
                d = {$urandom(), $urandom()};
                if (b == nb-1 || $urandom_range(3, 0) == 0) k = 8'($urandom);
                else k = 8'hFF;
                for (int l = 0; l < 8; l++) if (k[l]) q.push_back(d[8*l +: 8]);
                drive(1'b1, b == 0, b == nb-1, d, k);
                if (b != nb-1) begin
                    sp = sp | out_valid | out_err;
                    for (int j = 0; j < $urandom_range(2, 0); j++) begin
                        idle(1);
                        sp = sp | out_valid | out_err;
                    end
                end
            end
            ec = ref_crc(q);
            vectors++;
            if (out_valid !== 1'b1 || out_crc !== ec || out_len !== 16'(q.size()) || out_err !== 1'b0
                || out_fcs_ok !== exp_ok(ec) || sp !== 1'b0) begin
                miscompares++;
                $display("FAIL random_%0d got v=%b crc=%h len=%0d err=%b ok=%b sp=%b want 1/%h/%0d/0/%b/0",
                         f, out_valid, out_crc, out_len, out_err, out_fcs_ok, sp, ec, q.size(), exp_ok(ec));
            end
            if ($urandom_range(1, 0) == 1) idle(1);
        end
        idle(1);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = 64'h0; in_keep = 8'h00;
        test_reset;
        test_known;
        test_single_repeat;
        test_back_to_back;
        test_missing_eop;
        test_fcs;
        test_reset_midframe;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
